// File: rtl/rab_pkg.sv
// Shared types for the RAB address-channel buffers: FSM state encoding and the
// request record held in the per-port input FIFO.
package rab_pkg;

    localparam int RAB_ADDR_W   = 32;
    localparam int RAB_LEN_W    = 8;
    localparam int RAB_SIZE_W   = 3;
    localparam int RAB_CNT_W    = 16;
    // ID field is sized for the widest supported C_AXI_ID_WIDTH; narrower ports use the low bits
    localparam int RAB_MAX_ID_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FWD    = 2'd2,
        DROP   = 2'd3
    } rab_state_e;

    typedef struct packed {
        logic [RAB_ADDR_W-1:0]   addr;
        logic [RAB_MAX_ID_W-1:0] id;
        logic [RAB_LEN_W-1:0]    len;
        logic [RAB_SIZE_W-1:0]   size;
    } rab_req_t;

endpackage

// File: rtl/rab_ax_fifo.sv
// Small synchronous FIFO of request records; the head entry is visible
// combinationally so the lookup side can present it without an extra cycle.
module rab_ax_fifo
    import rab_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  rab_req_t push_data,
    input  logic     pop,
    output rab_req_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    rab_req_t         mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[PTR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/rab_ax_buffer.sv
// One lookup side of the RAB core: buffers AR/AW beats, presents the head for
// translation, then forwards accepted requests or hands dropped ones to the error responder.
module rab_ax_buffer
    import rab_pkg::*;
#(
    parameter int   C_AXI_ID_WIDTH = 8,
    parameter int   FIFO_DEPTH     = 2,
    parameter logic IS_WRITE       = 1'b0
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_areset,

    input  logic [31:0]               s_ax_addr,
    input  logic [C_AXI_ID_WIDTH-1:0] s_ax_id,
    input  logic [7:0]                s_ax_len,
    input  logic [2:0]                s_ax_size,
    input  logic                      s_ax_valid,
    output logic                      s_ax_ready,

    output logic [31:0]               rab_addr,
    output logic [C_AXI_ID_WIDTH-1:0] rab_id,
    output logic [7:0]                rab_len,
    output logic [2:0]                rab_size,
    output logic                      rab_type,
    output logic                      rab_addr_valid,
    input  logic                      rab_accept,
    input  logic                      rab_drop,
    input  logic [31:0]               rab_out_addr,
    output logic                      rab_sent,

    output logic [31:0]               m_ax_addr,
    output logic [C_AXI_ID_WIDTH-1:0] m_ax_id,
    output logic [7:0]                m_ax_len,
    output logic [2:0]                m_ax_size,
    output logic                      m_ax_valid,
    input  logic                      m_ax_ready,

    output logic                      drop_valid,
    input  logic                      drop_ready,
    output logic [C_AXI_ID_WIDTH-1:0] drop_id,
    output logic [7:0]                drop_len,
    output logic [15:0]               drop_cnt
);

    function automatic logic [RAB_CNT_W-1:0] sat_inc(input logic [RAB_CNT_W-1:0] v);
        return (&v) ? v : v + RAB_CNT_W'(1);
    endfunction

    rab_state_e state_q;
    rab_state_e state_d;
    rab_req_t   req_in;
    rab_req_t   head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic       is_lookup;
    logic       take_accept;
    logic       take_drop;
    logic       unused_head_id;

    always_comb begin
        req_in = '0;
        req_in.addr = s_ax_addr;
        req_in.id[C_AXI_ID_WIDTH-1:0] = s_ax_id;
        req_in.len = s_ax_len;
        req_in.size = s_ax_size;
    end

    // Ready is held low during reset so no beat is taken while pointers clear
    assign s_ax_ready = ~fifo_full & ~s_axi_areset;
    assign fifo_push  = s_ax_valid & s_ax_ready;

    assign is_lookup   = (state_q == LOOKUP);
    assign take_drop   = is_lookup & rab_drop;
    assign take_accept = is_lookup & rab_accept & ~rab_drop;
    assign fifo_pop    = take_accept | take_drop;

    rab_ax_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (s_axi_aclk),
        .rst       (s_axi_areset),
        .push      (fifo_push),
        .push_data (req_in),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        rab_sent = 1'b0;
        unique case (state_q)
            IDLE:   if (!fifo_empty) state_d = LOOKUP;
            LOOKUP: begin
                if (rab_drop)        state_d = DROP;
                else if (rab_accept) state_d = FWD;
            end
            FWD: begin
                if (m_ax_ready) begin
                    rab_sent = 1'b1;
                    state_d  = fifo_empty ? IDLE : LOOKUP;
                end
            end
            DROP:   if (drop_ready) state_d = fifo_empty ? IDLE : LOOKUP;
            default: state_d = IDLE;
        endcase
    end

    // Head fields are masked outside LOOKUP so the core never sees stale or unwritten entries
    assign rab_addr_valid = is_lookup;
    assign rab_addr       = is_lookup ? head.addr : '0;
    assign rab_id         = is_lookup ? head.id[C_AXI_ID_WIDTH-1:0] : '0;
    assign rab_len        = is_lookup ? head.len : '0;
    assign rab_size       = is_lookup ? head.size : '0;
    assign rab_type       = IS_WRITE;
    assign unused_head_id = ^head.id;

    assign m_ax_valid = (state_q == FWD);
    assign drop_valid = (state_q == DROP);

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            m_ax_addr <= '0;
            m_ax_id   <= '0;
            m_ax_len  <= '0;
            m_ax_size <= '0;
            drop_id   <= '0;
            drop_len  <= '0;
            drop_cnt  <= '0;
        end else begin
            if (take_accept) begin
                m_ax_addr <= rab_out_addr;
                m_ax_id   <= head.id[C_AXI_ID_WIDTH-1:0];
                m_ax_len  <= head.len;
                m_ax_size <= head.size;
            end
            if (take_drop) begin
                drop_id  <= head.id[C_AXI_ID_WIDTH-1:0];
                drop_len <= head.len;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_rab_ax_buffer.sv
// Directed bench for rab_ax_buffer: single accept, drop, FIFO full ordering,
// accept/drop collision, reset in flight and drop counter saturation.
module tb_rab_ax_buffer;

    logic        s_axi_aclk = 1'b0;
    logic        s_axi_areset;
    logic [31:0] s_ax_addr;
    logic [7:0]  s_ax_id;
    logic [7:0]  s_ax_len;
    logic [2:0]  s_ax_size;
    logic        s_ax_valid;
    logic        s_ax_ready;
    logic [31:0] rab_addr;
    logic [7:0]  rab_id;
    logic [7:0]  rab_len;
    logic [2:0]  rab_size;
    logic        rab_type;
    logic        rab_addr_valid;
    logic        rab_accept;
    logic        rab_drop;
    logic [31:0] rab_out_addr;
    logic        rab_sent;
    logic [31:0] m_ax_addr;
    logic [7:0]  m_ax_id;
    logic [7:0]  m_ax_len;
    logic [2:0]  m_ax_size;
    logic        m_ax_valid;
    logic        m_ax_ready;
    logic        drop_valid;
    logic        drop_ready;
    logic [7:0]  drop_id;
    logic [7:0]  drop_len;
    logic [15:0] drop_cnt;

    int vectors = 0;
    int miscompares = 0;
    int sent_cnt = 0;
    int drop_hs = 0;

    rab_ax_buffer #(
        .C_AXI_ID_WIDTH (8),
        .FIFO_DEPTH     (2),
        .IS_WRITE       (1'b0)
    ) dut (
        .s_axi_aclk     (s_axi_aclk),
        .s_axi_areset   (s_axi_areset),
        .s_ax_addr      (s_ax_addr),
        .s_ax_id        (s_ax_id),
        .s_ax_len       (s_ax_len),
        .s_ax_size      (s_ax_size),
        .s_ax_valid     (s_ax_valid),
        .s_ax_ready     (s_ax_ready),
        .rab_addr       (rab_addr),
        .rab_id         (rab_id),
        .rab_len        (rab_len),
        .rab_size       (rab_size),
        .rab_type       (rab_type),
        .rab_addr_valid (rab_addr_valid),
        .rab_accept     (rab_accept),
        .rab_drop       (rab_drop),
        .rab_out_addr   (rab_out_addr),
        .rab_sent       (rab_sent),
        .m_ax_addr      (m_ax_addr),
        .m_ax_id        (m_ax_id),
        .m_ax_len       (m_ax_len),
        .m_ax_size      (m_ax_size),
        .m_ax_valid     (m_ax_valid),
        .m_ax_ready     (m_ax_ready),
        .drop_valid     (drop_valid),
        .drop_ready     (drop_ready),
        .drop_id        (drop_id),
        .drop_len       (drop_len),
        .drop_cnt       (drop_cnt)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    always @(posedge s_axi_aclk) begin
        if (!s_axi_areset) begin
            if (rab_sent) sent_cnt++;
            if (drop_valid && drop_ready) drop_hs++;
        end
    end

    task automatic step();
        @(posedge s_axi_aclk);
        #1;
    endtask

    task automatic clear_inputs();
        s_ax_addr = '0; s_ax_id = '0; s_ax_len = '0; s_ax_size = '0; s_ax_valid = 1'b0;
        rab_accept = 1'b0; rab_drop = 1'b0; rab_out_addr = '0;
        m_ax_ready = 1'b0; drop_ready = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        s_axi_areset = 1'b1;
        step();
        step();
        s_axi_areset = 1'b0;
        #1;
    endtask

    task automatic push_req(input logic [31:0] a, input logic [7:0] id,
                            input logic [7:0] len, input logic [2:0] size, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (s_ax_ready) ok = 1'b1;
            else step();
        end
        if (ok) begin
            s_ax_addr = a; s_ax_id = id; s_ax_len = len; s_ax_size = size; s_ax_valid = 1'b1;
            step();
            s_ax_valid = 1'b0;
        end
    endtask

    task automatic wait_lookup(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rab_addr_valid) ok = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        s_axi_areset = 1'b1;
        step();
        vectors++; if (s_ax_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready got %b want 0", s_ax_ready); end
        vectors++; if (rab_addr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_addr_valid got %b want 0", rab_addr_valid); end
        vectors++; if (m_ax_valid !== 1'b0 || m_ax_addr !== 32'h0) begin miscompares++; $display("FAIL reset_m_ax got v=%b a=%h want 0/0", m_ax_valid, m_ax_addr); end
        vectors++; if (drop_valid !== 1'b0 || drop_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_drop got v=%b cnt=%h want 0/0", drop_valid, drop_cnt); end
        vectors++; if (rab_type !== 1'b0) begin miscompares++; $display("FAIL reset_type got %b want 0", rab_type); end
        s_axi_areset = 1'b0;
        #1;
        vectors++; if (s_ax_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_s_ready got %b want 1", s_ax_ready); end
    endtask

    task automatic test_single_read();
        logic ok;
        int sent0;
        sent0 = sent_cnt;
        push_req(32'h0000_1000, 8'd3, 8'd7, 3'd2, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_push got timeout want accepted"); end
        vectors++; if (rab_addr_valid !== 1'b0) begin miscompares++; $display("FAIL single_latency_t1 got %b want 0", rab_addr_valid); end
        step();
        vectors++; if (rab_addr_valid !== 1'b1) begin miscompares++; $display("FAIL single_latency_t2 got %b want 1", rab_addr_valid); end
        vectors++; if (rab_addr !== 32'h1000 || rab_id !== 8'd3 || rab_len !== 8'd7) begin miscompares++; $display("FAIL single_head got %h/%0d/%0d want 1000/3/7", rab_addr, rab_id, rab_len); end
        rab_accept = 1'b1; rab_out_addr = 32'h8000_1000;
        step();
        rab_accept = 1'b0;
        vectors++; if (m_ax_valid !== 1'b1 || rab_addr_valid !== 1'b0) begin miscompares++; $display("FAIL single_fwd got mv=%b av=%b want 1/0", m_ax_valid, rab_addr_valid); end
        vectors++; if (m_ax_addr !== 32'h8000_1000 || m_ax_id !== 8'd3 || m_ax_len !== 8'd7 || m_ax_size !== 3'd2) begin miscompares++; $display("FAIL single_m_fields got %h/%0d/%0d/%0d want 80001000/3/7/2", m_ax_addr, m_ax_id, m_ax_len, m_ax_size); end
        vectors++; if (rab_sent !== 1'b0) begin miscompares++; $display("FAIL single_sent_early got %b want 0", rab_sent); end
        m_ax_ready = 1'b1;
        #1;
        vectors++; if (rab_sent !== 1'b1) begin miscompares++; $display("FAIL single_sent got %b want 1", rab_sent); end
        step();
        vectors++; if (m_ax_valid !== 1'b0 || rab_sent !== 1'b0) begin miscompares++; $display("FAIL single_after_hs got mv=%b sent=%b want 0/0", m_ax_valid, rab_sent); end
        m_ax_ready = 1'b0;
        vectors++; if (sent_cnt - sent0 !== 1) begin miscompares++; $display("FAIL single_sent_count got %0d want 1", sent_cnt - sent0); end
    endtask

    task automatic test_drop();
        logic ok;
        int sent0;
        sent0 = sent_cnt;
        push_req(32'h0000_2000, 8'd5, 8'd2, 3'd0, ok);
        wait_lookup(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL drop_lookup got timeout want addr_valid"); end
        rab_drop = 1'b1;
        step();
        rab_drop = 1'b0;
        vectors++; if (drop_valid !== 1'b1 || m_ax_valid !== 1'b0) begin miscompares++; $display("FAIL drop_valid got dv=%b mv=%b want 1/0", drop_valid, m_ax_valid); end
        vectors++; if (drop_id !== 8'd5 || drop_len !== 8'd2 || drop_cnt !== 16'd1) begin miscompares++; $display("FAIL drop_fields got %0d/%0d/%0d want 5/2/1", drop_id, drop_len, drop_cnt); end
        step();
        vectors++; if (drop_valid !== 1'b1 || drop_id !== 8'd5) begin miscompares++; $display("FAIL drop_hold got dv=%b id=%0d want 1/5", drop_valid, drop_id); end
        drop_ready = 1'b1;
        step();
        drop_ready = 1'b0;
        vectors++; if (drop_valid !== 1'b0 || rab_addr_valid !== 1'b0) begin miscompares++; $display("FAIL drop_release got dv=%b av=%b want 0/0", drop_valid, rab_addr_valid); end
        vectors++; if (sent_cnt !== sent0) begin miscompares++; $display("FAIL drop_no_sent got %0d want %0d", sent_cnt, sent0); end
    endtask

    task automatic test_accept_drop_same();
        logic ok;
        int sent0;
        sent0 = sent_cnt;
        push_req(32'h0000_3000, 8'd7, 8'd4, 3'd1, ok);
        wait_lookup(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL both_lookup got timeout want addr_valid"); end
        rab_accept = 1'b1; rab_drop = 1'b1; rab_out_addr = 32'h8000_3000;
        step();
        rab_accept = 1'b0; rab_drop = 1'b0;
        vectors++; if (m_ax_valid !== 1'b0 || drop_valid !== 1'b1) begin miscompares++; $display("FAIL both_path got mv=%b dv=%b want 0/1", m_ax_valid, drop_valid); end
        vectors++; if (drop_id !== 8'd7 || drop_len !== 8'd4 || drop_cnt !== 16'd2) begin miscompares++; $display("FAIL both_fields got %0d/%0d/%0d want 7/4/2", drop_id, drop_len, drop_cnt); end
        drop_ready = 1'b1;
        step();
        drop_ready = 1'b0;
        vectors++; if (drop_valid !== 1'b0 || m_ax_valid !== 1'b0 || sent_cnt !== sent0) begin miscompares++; $display("FAIL both_after got dv=%b mv=%b sent=%0d want 0/0/%0d", drop_valid, m_ax_valid, sent_cnt, sent0); end
    endtask

    task automatic test_fifo_full();
        logic ok;
        apply_reset();
        push_req(32'h0000_A000, 8'd1, 8'd0, 3'd0, ok);
        wait_lookup(ok);
        rab_accept = 1'b1; rab_out_addr = 32'h9000_A000;
        step();
        rab_accept = 1'b0;
        push_req(32'h0000_B000, 8'd2, 8'd1, 3'd1, ok);
        vectors++; if (s_ax_ready !== 1'b1) begin miscompares++; $display("FAIL full_after_b got %b want 1", s_ax_ready); end
        push_req(32'h0000_C000, 8'd3, 8'd2, 3'd2, ok);
        vectors++; if (s_ax_ready !== 1'b0) begin miscompares++; $display("FAIL full_after_c got %b want 0", s_ax_ready); end
        vectors++; if (m_ax_valid !== 1'b1 || m_ax_addr !== 32'h9000_A000) begin miscompares++; $display("FAIL full_a_fwd got mv=%b a=%h want 1/9000a000", m_ax_valid, m_ax_addr); end
        m_ax_ready = 1'b1;
        step();
        m_ax_ready = 1'b0;
        vectors++; if (rab_addr_valid !== 1'b1 || rab_addr !== 32'h0000_B000 || rab_id !== 8'd2) begin miscompares++; $display("FAIL full_head_b got av=%b a=%h id=%0d want 1/b000/2", rab_addr_valid, rab_addr, rab_id); end
        rab_accept = 1'b1; rab_out_addr = 32'h9000_B000;
        step();
        rab_accept = 1'b0;
        vectors++; if (m_ax_addr !== 32'h9000_B000 || m_ax_id !== 8'd2 || m_ax_len !== 8'd1) begin miscompares++; $display("FAIL full_m_b got %h/%0d/%0d want 9000b000/2/1", m_ax_addr, m_ax_id, m_ax_len); end
        vectors++; if (s_ax_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_back got %b want 1", s_ax_ready); end
        m_ax_ready = 1'b1;
        step();
        m_ax_ready = 1'b0;
        vectors++; if (rab_addr !== 32'h0000_C000 || rab_id !== 8'd3 || rab_len !== 8'd2) begin miscompares++; $display("FAIL full_head_c got %h/%0d/%0d want c000/3/2", rab_addr, rab_id, rab_len); end
        rab_accept = 1'b1; rab_out_addr = 32'h9000_C000;
        step();
        rab_accept = 1'b0;
        vectors++; if (m_ax_addr !== 32'h9000_C000 || m_ax_size !== 3'd2) begin miscompares++; $display("FAIL full_m_c got %h/%0d want 9000c000/2", m_ax_addr, m_ax_size); end
        m_ax_ready = 1'b1;
        step();
        m_ax_ready = 1'b0;
        vectors++; if (m_ax_valid !== 1'b0 || rab_addr_valid !== 1'b0) begin miscompares++; $display("FAIL full_drained got mv=%b av=%b want 0/0", m_ax_valid, rab_addr_valid); end
    endtask

    task automatic test_reset_in_fwd();
        logic ok;
        int sent0;
        apply_reset();
        push_req(32'h0000_4000, 8'd1, 8'd1, 3'd1, ok);
        wait_lookup(ok);
        rab_accept = 1'b1; rab_out_addr = 32'h8000_4000;
        step();
        rab_accept = 1'b0;
        push_req(32'h0000_5000, 8'd2, 8'd2, 3'd2, ok);
        vectors++; if (m_ax_valid !== 1'b1) begin miscompares++; $display("FAIL rst_fwd_pre got %b want 1", m_ax_valid); end
        sent0 = sent_cnt;
        s_axi_areset = 1'b1;
        step();
        m_ax_ready = 1'b1;
        #1;
        vectors++; if (m_ax_valid !== 1'b0 || m_ax_addr !== 32'h0 || m_ax_id !== 8'h0) begin miscompares++; $display("FAIL rst_fwd_m got mv=%b a=%h id=%0d want 0/0/0", m_ax_valid, m_ax_addr, m_ax_id); end
        vectors++; if (rab_addr_valid !== 1'b0 || rab_addr !== 32'h0 || rab_sent !== 1'b0) begin miscompares++; $display("FAIL rst_fwd_rab got av=%b a=%h sent=%b want 0/0/0", rab_addr_valid, rab_addr, rab_sent); end
        vectors++; if (s_ax_ready !== 1'b0 || drop_valid !== 1'b0) begin miscompares++; $display("FAIL rst_fwd_misc got rdy=%b dv=%b want 0/0", s_ax_ready, drop_valid); end
        s_axi_areset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++; if (rab_addr_valid !== 1'b0 || m_ax_valid !== 1'b0) begin miscompares++; $display("FAIL rst_fwd_stale cycle %0d got av=%b mv=%b want 0/0", i, rab_addr_valid, m_ax_valid); end
        end
        m_ax_ready = 1'b0;
        vectors++; if (sent_cnt !== sent0) begin miscompares++; $display("FAIL rst_fwd_sent got %0d want %0d", sent_cnt, sent0); end
    endtask

    task automatic test_saturate();
        int base;
        int sent0;
        apply_reset();
        base = drop_hs;
        sent0 = sent_cnt;
        s_ax_addr = 32'h0000_6000; s_ax_id = 8'd9; s_ax_len = 8'd3; s_ax_valid = 1'b1;
        rab_drop = 1'b1; drop_ready = 1'b1;
        for (int i = 0; i < 140000 && (drop_hs - base) < 65540; i++) @(posedge s_axi_aclk);
        #1;
        clear_inputs();
        vectors++; if (drop_hs - base < 65540) begin miscompares++; $display("FAIL sat_drops got %0d want >=65540", drop_hs - base); end
        vectors++; if (drop_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_cnt got %h want ffff", drop_cnt); end
        vectors++; if (sent_cnt !== sent0) begin miscompares++; $display("FAIL sat_sent got %0d want %0d", sent_cnt, sent0); end
    endtask

    initial begin
        s_axi_areset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_drop();
        test_accept_drop_same();
        test_fifo_full();
        test_reset_in_fwd();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
